// File: rtl/dna_seq_gen_if.sv
// Symbol generator bus: request side (start, pattern, repeat_cnt, gap_len),
// downstream handshake (ready, x, valid) and status (busy, done).
//   master : the generator (drives x/valid/busy/done, samples the rest)
//   slave  : the requester/consumer side
interface dna_seq_gen_if #(
   parameter int unsigned PAT_LEN = 6
) ();
   logic                 start;
   logic [2*PAT_LEN-1:0] pattern;
   logic [3:0]           repeat_cnt;
   logic [3:0]           gap_len;
   logic                 ready;
   logic [1:0]           x;
   logic                 valid;
   logic                 busy;
   logic                 done;

   modport master (
      input  start, pattern, repeat_cnt, gap_len, ready,
      output x, valid, busy, done
   );

   modport slave (
      output start, pattern, repeat_cnt, gap_len, ready,
      input  x, valid, busy, done
   );
endinterface

// File: rtl/dna_seq_gen.sv
// DNA symbol sequence generator.
// Emits a latched pattern of 2-bit nucleotides (A=00 T=01 C=10 G=11)
// repeat_cnt times over a valid/ready handshake, separated by gap_len
// LFSR-driven filler symbols (C or G only), then pulses done for one cycle.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : dna_seq_gen_if master modport (request, handshake, status)
module dna_seq_gen #(
   parameter int unsigned PAT_LEN   = 6,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic          clk,
   input  logic          rst,
   dna_seq_gen_if.master bus
);
   localparam int unsigned PAT_W = 2 * PAT_LEN;
   localparam int unsigned IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LFSR_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [PAT_W-1:0]    pat_q, pat_d;
   logic [CNT_W-1:0]    rep_q, rep_d;
   logic [CNT_W-1:0]    gap_len_q, gap_len_d;
   logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [1:0]          x_q, x_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                xfer_c;
   logic [1:0]          sym_c;

   assign xfer_c = valid_q & bus.ready;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         rep_q     <= '0;
         gap_len_q <= '0;
         gap_cnt_q <= '0;
         idx_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         x_q       <= 2'b00;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         rep_q     <= rep_d;
         gap_len_q <= gap_len_d;
         gap_cnt_q <= gap_cnt_d;
         idx_q     <= idx_d;
         lfsr_q    <= lfsr_d;
         x_q       <= x_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and counter logic; everything holds unless a transfer occurs
   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      rep_d     = rep_q;
      gap_len_d = gap_len_q;
      gap_cnt_d = gap_cnt_q;
      idx_d     = idx_q;
      lfsr_d    = lfsr_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               pat_d     = bus.pattern;
               rep_d     = bus.repeat_cnt;
               gap_len_d = bus.gap_len;
               idx_d     = '0;
               gap_cnt_d = '0;
               state_d   = (bus.repeat_cnt != '0) ? SEND : FIN;
            end
         end
         SEND: begin
            if (xfer_c) begin
               if (idx_q == IDX_W'(PAT_LEN - 1)) begin
                  idx_d = '0;
                  rep_d = rep_q - CNT_W'(1);
                  // rep_q==1 means this was the last repetition: no trailing gap
                  if (rep_q == CNT_W'(1)) begin
                     state_d = FIN;
                  end else if (gap_len_q == '0) begin
                     state_d = SEND;
                  end else begin
                     state_d   = GAP;
                     gap_cnt_d = '0;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         GAP: begin
            if (xfer_c) begin
               // Fibonacci taps 8,6,5,4 shifted left into bit 0
               lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
               if (gap_cnt_q == gap_len_q - CNT_W'(1)) begin
                  state_d   = SEND;
                  gap_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q + CNT_W'(1);
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: registered outputs are computed from the next state so
   // the first symbol appears the cycle after start and holds under stall
   always_comb begin
      x_d     = 2'b00;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      sym_c   = 2'b00;
      for (int unsigned i = 0; i < PAT_LEN; i++) begin
         if (idx_d == IDX_W'(i)) begin
            sym_c = pat_d[2*i +: 2];
         end
      end
      case (state_d)
         SEND: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            x_d     = sym_c;
         end
         GAP: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            // Filler is C or G only, never A
            x_d     = {1'b1, lfsr_d[0]};
         end
         FIN: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign bus.x     = x_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_dna_seq_gen.sv
// Directed self-checking bench for dna_seq_gen.
module tb_dna_seq_gen;
   localparam int unsigned PAT_LEN = 6;

   logic clk = 1'b0;
   logic rst;

   dna_seq_gen_if #(.PAT_LEN(PAT_LEN)) bus ();

   dna_seq_gen #(
      .PAT_LEN   (PAT_LEN),
      .LFSR_SEED (8'hA5)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc_last = 0;
   logic [1:0] got_q[$];
   logic [1:0] exp_q[$];

   // One comparison: count it, report any mismatch
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Request a transmission, then scramble the request inputs to prove latching
   task automatic start_tx(input logic [11:0] pat, input logic [3:0] rep, input logic [3:0] gap);
      bus.start      = 1'b1;
      bus.pattern    = pat;
      bus.repeat_cnt = rep;
      bus.gap_len    = gap;
      step();
      bus.start      = 1'b0;
      bus.pattern    = 12'h000;
      bus.repeat_cnt = 4'hF;
      bus.gap_len    = 4'hF;
   endtask

   // Consume symbols until done; optional stall and stray start pulses
   task automatic collect(input int stall_at, input int stall_len, input logic [1:0] stall_x,
                          input bit start_noise);
      int  n = 0;
      int  stalled = 0;
      int  cyc = 0;
      bit  fin = 1'b0;
      got_q.delete();
      for (int k = 0; k < 400 && !fin; k++) begin
         bus.start = start_noise;
         if (bus.done) begin
            fin = 1'b1;
            bus.start = 1'b0;
            check("fin_valid", 32'(bus.valid), 32'd0);
         end else begin
            cyc++;
            if (n == stall_at && stalled < stall_len) begin
               bus.ready = 1'b0;
               stalled++;
               check("stall_valid", 32'(bus.valid), 32'd1);
               check("stall_x", 32'(bus.x), 32'(stall_x));
            end else begin
               bus.ready = 1'b1;
            end
            if (bus.valid && bus.ready) begin
               got_q.push_back(bus.x);
               n++;
               cyc_last = cyc;
            end
         end
         step();
      end
      bus.start = 1'b0;
      bus.ready = 1'b1;
      if (!fin) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("post_busy", 32'(bus.busy), 32'd0);
         check("post_done", 32'(bus.done), 32'd0);
      end
   endtask

   task automatic cmp_seq(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_sym%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
   endtask

   // Bench-side ATTCGC detector over the transferred symbol stream
   function automatic int count_attcgc();
      logic [1:0] ref6[6];
      int hits = 0;
      bit ok;
      ref6 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
      for (int i = 0; i + 6 <= got_q.size(); i++) begin
         ok = 1'b1;
         for (int j = 0; j < 6; j++) begin
            if (got_q[i+j] != ref6[j]) ok = 1'b0;
         end
         if (ok) hits++;
      end
      return hits;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a_cnt;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.pattern    = '0;
      bus.repeat_cnt = '0;
      bus.gap_len    = '0;
      bus.ready      = 1'b1;
      step();
      step();
      check("rst_x",     32'(bus.x),     32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_done",  32'(bus.done),  32'd0);
      rst = 1'b0;
      step();

      // Single repeat, stray start during SEND ignored
      start_tx(12'hB94, 4'd1, 4'd0);
      check("t1_first_valid", 32'(bus.valid), 32'd1);
      check("t1_first_x",     32'(bus.x),     32'd0);
      collect(-1, 0, 2'b00, 1'b1);
      exp_q = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
      cmp_seq("t1");
      check("t1_cycles", 32'(1 + cyc_last), 32'd7);

      // Two repeats with 3-symbol gap; LFSR A5 -> fillers G,C,G
      start_tx(12'hB94, 4'd2, 4'd3);
      collect(-1, 0, 2'b00, 1'b0);
      exp_q = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2,
                2'd3, 2'd2, 2'd3,
                2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
      cmp_seq("t2");
      check("t2_cycles", 32'(1 + cyc_last), 32'd16);

      // Backpressure at index 1 for 3 cycles
      start_tx(12'hB94, 4'd1, 4'd0);
      collect(1, 3, 2'b01, 1'b0);
      exp_q = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
      cmp_seq("t3");

      // Zero repeats: straight to FIN
      start_tx(12'hB94, 4'd0, 4'd5);
      check("t4_done",  32'(bus.done),  32'd1);
      check("t4_valid", 32'(bus.valid), 32'd0);
      check("t4_busy",  32'(bus.busy),  32'd1);
      step();
      check("t4_done_end",  32'(bus.done),  32'd0);
      check("t4_valid_end", 32'(bus.valid), 32'd0);
      check("t4_busy_end",  32'(bus.busy),  32'd0);

      // Reset at the 3rd symbol aborts silently and restores the LFSR seed
      start_tx(12'hB94, 4'd2, 4'd3);
      bus.ready = 1'b1;
      step();
      step();
      check("t5_third_x", 32'(bus.x), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_valid", 32'(bus.valid), 32'd0);
      check("t5_busy",  32'(bus.busy),  32'd0);
      check("t5_done",  32'(bus.done),  32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_no_done", 32'(bus.done), 32'd0);
      end
      start_tx(12'hB94, 4'd2, 4'd3);
      collect(-1, 0, 2'b00, 1'b0);
      exp_q = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2,
                2'd3, 2'd2, 2'd3,
                2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2};
      cmp_seq("t5");

      // Closed loop: 5 repeats, gap 4 -> 5 detections, no filler A
      start_tx(12'hB94, 4'd5, 4'd4);
      collect(-1, 0, 2'b00, 1'b0);
      check("t6_len",    32'(got_q.size()), 32'd46);
      check("t6_cycles", 32'(1 + cyc_last), 32'd47);
      check("t6_detect", 32'(count_attcgc()), 32'd5);
      a_cnt = 0;
      foreach (got_q[i]) if (got_q[i] == 2'b00) a_cnt++;
      check("t6_a_count", 32'(a_cnt), 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
